// File: rtl/bp_me_pkg.sv
// Shared types and helpers for the BP memory-engine request arbitration slice.
// Holds the burst arbiter state encoding and the round-robin index wrap helper.
package bp_me_pkg;

    typedef enum logic [1:0] {
        e_arb_idle = 2'd0,
        e_arb_hdr  = 2'd1,
        e_arb_data = 2'd2
    } bp_me_burst_arb_state_e;

    // Next requester index after idx, wrapping at n; out-of-range idx wraps to 0
    function automatic int unsigned bp_me_rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/bp_me_rr_picker.sv
// Combinational round-robin picker: first valid requester after the last-grant pointer.
// Produces a one-hot grant, its encoded index and an any-valid flag.
module bp_me_rr_picker
    import bp_me_pkg::*;
#(
    parameter  int unsigned num_req_p   = 4,
    localparam int unsigned id_width_lp = $clog2(num_req_p)
) (
    input  logic [num_req_p-1:0]   v_i,
    input  logic [id_width_lp-1:0] last_i,
    output logic [num_req_p-1:0]   grant_oh_o,
    output logic [id_width_lp-1:0] id_o,
    output logic                   any_v_o
);

    int unsigned idx;

    always_comb begin
        grant_oh_o = '0;
        id_o       = '0;
        any_v_o    = 1'b0;
        idx        = 32'(last_i);
        for (int unsigned k = 0; k < num_req_p; k++) begin
            idx = bp_me_rr_next(idx, num_req_p);
            if (!any_v_o && v_i[id_width_lp'(idx)]) begin
                any_v_o                          = 1'b1;
                id_o                             = id_width_lp'(idx);
                grant_oh_o[id_width_lp'(idx)]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bp_me_burst_req_arbiter.sv
// N-to-1 arbiter merging per-LCE burst request streams (header + data beats) onto the CCE port.
// Grant is round-robin and held for a whole message so beats of different messages never interleave.
module bp_me_burst_req_arbiter
    import bp_me_pkg::*;
#(
    parameter  int unsigned num_req_p      = 4,
    parameter  int unsigned header_width_p = 64,
    parameter  int unsigned data_width_p   = 64,
    parameter  int unsigned max_beats_p    = 8,
    localparam int unsigned beats_width_p  = $clog2(max_beats_p + 1),
    localparam int unsigned id_width_lp    = $clog2(num_req_p)
) (
    input  logic                                clk_i,
    input  logic                                reset_n_i,

    input  logic [num_req_p*header_width_p-1:0] req_header_i,
    input  logic [num_req_p*beats_width_p-1:0]  req_beats_i,
    input  logic [num_req_p-1:0]                req_header_v_i,
    output logic [num_req_p-1:0]                req_header_ready_o,
    input  logic [num_req_p*data_width_p-1:0]   req_data_i,
    input  logic [num_req_p-1:0]                req_data_v_i,
    output logic [num_req_p-1:0]                req_data_ready_o,

    output logic [header_width_p-1:0]           header_o,
    output logic                                header_v_o,
    input  logic                                header_ready_i,
    output logic [data_width_p-1:0]             data_o,
    output logic                                data_v_o,
    input  logic                                data_ready_i,

    output logic [id_width_lp-1:0]              grant_id_o,
    output logic                                busy_o
);

    localparam logic [beats_width_p-1:0] max_beats_lp = beats_width_p'(max_beats_p);
    localparam logic [id_width_lp-1:0]   last_rst_lp  = id_width_lp'(num_req_p - 1);

    bp_me_burst_arb_state_e state_r, state_n;
    logic [beats_width_p-1:0] cnt_r, cnt_n;
    logic [id_width_lp-1:0]   grant_r, grant_n;
    logic [id_width_lp-1:0]   last_grant_r, last_grant_n;

    logic [header_width_p-1:0] hdr_arr   [num_req_p];
    logic [data_width_p-1:0]   data_arr  [num_req_p];
    logic [beats_width_p-1:0]  beats_arr [num_req_p];

    logic [num_req_p-1:0]   pick_oh;
    logic [id_width_lp-1:0] pick_id;
    logic                   pick_any;

    always_comb begin
        for (int unsigned i = 0; i < num_req_p; i++) begin
            hdr_arr[i]   = req_header_i[i*header_width_p +: header_width_p];
            data_arr[i]  = req_data_i[i*data_width_p +: data_width_p];
            beats_arr[i] = req_beats_i[i*beats_width_p +: beats_width_p];
        end
    end

    bp_me_rr_picker #(
        .num_req_p (num_req_p)
    ) u_picker (
        .v_i        (req_header_v_i),
        .last_i     (last_grant_r),
        .grant_oh_o (pick_oh),
        .id_o       (pick_id),
        .any_v_o    (pick_any)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r      <= e_arb_idle;
            cnt_r        <= '0;
            grant_r      <= '0;
            last_grant_r <= last_rst_lp;
        end else begin
            state_r      <= state_n;
            cnt_r        <= cnt_n;
            grant_r      <= grant_n;
            last_grant_r <= last_grant_n;
        end
    end

    // Outputs are muxed from the held grant only; idle drives nothing so the
    // one-cycle arbitration bubble never exposes an unlatched winner.
    always_comb begin
        state_n            = state_r;
        cnt_n              = cnt_r;
        grant_n            = grant_r;
        last_grant_n       = last_grant_r;
        header_o           = '0;
        header_v_o         = 1'b0;
        data_o             = '0;
        data_v_o           = 1'b0;
        req_header_ready_o = '0;
        req_data_ready_o   = '0;

        unique case (state_r)
            e_arb_idle: begin
                if (pick_any) begin
                    grant_n      = pick_id;
                    last_grant_n = pick_id;
                    cnt_n        = beats_arr[pick_id];
                    state_n      = e_arb_hdr;
                end
            end
            e_arb_hdr: begin
                header_o                    = hdr_arr[grant_r];
                header_v_o                  = req_header_v_i[grant_r];
                req_header_ready_o[grant_r] = header_ready_i;
                if (header_v_o && header_ready_i) begin
                    state_n = (cnt_r == '0) ? e_arb_idle : e_arb_data;
                end
            end
            e_arb_data: begin
                data_o                    = data_arr[grant_r];
                data_v_o                  = req_data_v_i[grant_r];
                req_data_ready_o[grant_r] = data_ready_i;
                if (data_v_o && data_ready_i) begin
                    cnt_n = cnt_r - 1'b1;
                    if (cnt_r == beats_width_p'(1)) begin
                        state_n = e_arb_idle;
                    end
                end
            end
            default: begin
                state_n = e_arb_idle;
            end
        endcase
    end

    assign grant_id_o = grant_r;
    assign busy_o     = (state_r != e_arb_idle);

    a_beats_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (state_r == e_arb_idle && pick_any) |-> (beats_arr[pick_id] <= max_beats_lp));

    a_pick_onehot: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        pick_any |-> $onehot(pick_oh));

    a_header_held: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (state_r == e_arb_hdr) |-> req_header_v_i[grant_r]);

endmodule

// File: tb/tb_bp_me_burst_req_arbiter.sv
// Scoreboard bench for bp_me_burst_req_arbiter: requester models feed directed messages,
// expected CCE-side transfers are queued in grant order and checked by a monitor.
module tb_bp_me_burst_req_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned HW = 64;
    localparam int unsigned DW = 64;
    localparam int unsigned BW = 4;

    typedef struct {
        logic [63:0] hdr;
        int unsigned beats;
        logic [63:0] dbase;
    } msg_t;

    typedef struct {
        bit          is_data;
        int unsigned id;
        logic [63:0] val;
    } ev_t;

    logic              clk_i;
    logic              reset_n_i;
    logic [NR*HW-1:0]  req_header_i;
    logic [NR*BW-1:0]  req_beats_i;
    logic [NR-1:0]     req_header_v_i;
    logic [NR-1:0]     req_header_ready_o;
    logic [NR*DW-1:0]  req_data_i;
    logic [NR-1:0]     req_data_v_i;
    logic [NR-1:0]     req_data_ready_o;
    logic [HW-1:0]     header_o;
    logic              header_v_o;
    logic              header_ready_i;
    logic [DW-1:0]     data_o;
    logic              data_v_o;
    logic              data_ready_i;
    logic [1:0]        grant_id_o;
    logic              busy_o;

    msg_t        rq [NR][$];
    ev_t         exp_q [$];
    int unsigned hdr_cyc [$];
    int unsigned cyc;
    int unsigned n_cmp;
    int unsigned n_err;
    logic [BW-1:0] bxor [NR];

    bp_me_burst_req_arbiter #(
        .num_req_p      (NR),
        .header_width_p (HW),
        .data_width_p   (DW),
        .max_beats_p    (8)
    ) dut (
        .clk_i              (clk_i),
        .reset_n_i          (reset_n_i),
        .req_header_i       (req_header_i),
        .req_beats_i        (req_beats_i),
        .req_header_v_i     (req_header_v_i),
        .req_header_ready_o (req_header_ready_o),
        .req_data_i         (req_data_i),
        .req_data_v_i       (req_data_v_i),
        .req_data_ready_o   (req_data_ready_o),
        .header_o           (header_o),
        .header_v_o         (header_v_o),
        .header_ready_i     (header_ready_i),
        .data_o             (data_o),
        .data_v_o           (data_v_o),
        .data_ready_i       (data_ready_i),
        .grant_id_o         (grant_id_o),
        .busy_o             (busy_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk_i);
            cyc++;
        end
    end

    function automatic logic [63:0] mk_hdr(input int unsigned id, input logic [7:0] tag);
        return 64'hA000_0000_0000_0000 | (64'(id) << 16) | 64'(tag);
    endfunction

    function automatic logic [63:0] mk_dbase(input int unsigned id, input logic [7:0] tag);
        return 64'hD000_0000_0000_0000 | (64'(id) << 16) | (64'(tag) << 8);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Queue a message at requester id; only the first exp_beats beats are expected downstream
    task automatic push_msg(input int unsigned id, input logic [7:0] tag,
                            input int unsigned beats, input int unsigned exp_beats);
        msg_t m;
        ev_t  e;
        m.hdr   = mk_hdr(id, tag);
        m.beats = beats;
        m.dbase = mk_dbase(id, tag);
        rq[id].push_back(m);
        e.is_data = 1'b0;
        e.id      = id;
        e.val     = m.hdr;
        exp_q.push_back(e);
        for (int unsigned b = 0; b < exp_beats; b++) begin
            e.is_data = 1'b1;
            e.val     = m.dbase + 64'(b);
            exp_q.push_back(e);
        end
    endtask

    function automatic bit rq_empty();
        for (int unsigned i = 0; i < NR; i++) begin
            if (rq[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic wait_drain(input int unsigned max_cyc, input string name);
        bit done;
        done = 1'b0;
        for (int unsigned k = 0; k < max_cyc; k++) begin
            @(posedge clk_i);
            #2;
            if (exp_q.size() == 0 && rq_empty()) begin
                done = 1'b1;
                break;
            end
        end
        chk(name, 64'(done), 64'd1);
    endtask

    // Requester models: header first, data beats only after the header is accepted
    initial begin
        int unsigned ph [NR];
        int unsigned bi [NR];
        bit          hf [NR];
        bit          df [NR];
        msg_t        m;
        req_header_i   = '0;
        req_beats_i    = '0;
        req_header_v_i = '0;
        req_data_i     = '0;
        req_data_v_i   = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            ph[i] = 0;
            bi[i] = 0;
        end
        forever begin
            @(negedge clk_i);
            for (int unsigned i = 0; i < NR; i++) begin
                hf[i] = req_header_v_i[i] & req_header_ready_o[i];
                df[i] = req_data_v_i[i] & req_data_ready_o[i];
            end
            @(posedge clk_i);
            #1;
            for (int unsigned i = 0; i < NR; i++) begin
                if (!reset_n_i) begin
                    ph[i] = 0;
                    bi[i] = 0;
                end else if (ph[i] == 0 && hf[i] && rq[i].size() != 0) begin
                    m = rq[i][0];
                    if (m.beats == 0) begin
                        void'(rq[i].pop_front());
                    end else begin
                        ph[i] = 1;
                        bi[i] = 0;
                    end
                end else if (ph[i] == 1 && df[i] && rq[i].size() != 0) begin
                    m = rq[i][0];
                    bi[i]++;
                    if (bi[i] == m.beats) begin
                        void'(rq[i].pop_front());
                        ph[i] = 0;
                        bi[i] = 0;
                    end
                end
                req_header_v_i[i]       = 1'b0;
                req_data_v_i[i]         = 1'b0;
                req_header_i[i*HW +: HW] = '0;
                req_data_i[i*DW +: DW]   = '0;
                if (rq[i].size() != 0) begin
                    m = rq[i][0];
                    if (ph[i] == 0) begin
                        req_header_v_i[i]        = 1'b1;
                        req_header_i[i*HW +: HW] = m.hdr;
                        req_beats_i[i*BW +: BW]  = BW'(m.beats) ^ bxor[i];
                    end else begin
                        req_data_v_i[i]        = 1'b1;
                        req_data_i[i*DW +: DW] = m.dbase + 64'(bi[i]);
                    end
                end
            end
        end
    end

    // Monitor: every downstream transfer must match the head of the expected queue
    initial begin
        ev_t e;
        forever begin
            @(negedge clk_i);
            if (reset_n_i) begin
                if (header_v_o && header_ready_i) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_header", header_o, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ev_kind_hdr", 64'(e.is_data), 64'd0);
                        chk("hdr_grant_id", 64'(grant_id_o), 64'(e.id));
                        chk("hdr_value", header_o, e.val);
                        hdr_cyc.push_back(cyc);
                    end
                end
                if (data_v_o && data_ready_i) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_data", data_o, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ev_kind_data", 64'(e.is_data), 64'd1);
                        chk("data_grant_id", 64'(grant_id_o), 64'(e.id));
                        chk("data_value", data_o, e.val);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached with %0d expected transfers pending", exp_q.size());
        $fatal(1);
    end

    initial begin
        bit ok;
        bit seen;
        n_cmp = 0;
        n_err = 0;
        for (int unsigned i = 0; i < NR; i++) bxor[i] = '0;
        reset_n_i      = 1'b0;
        header_ready_i = 1'b1;
        data_ready_i   = 1'b1;

        // Reset with every requester holding a header; then 0,1,2,3,0 with one idle cycle between
        push_msg(0, 8'h30, 0, 0);
        push_msg(1, 8'h31, 0, 0);
        push_msg(2, 8'h32, 0, 0);
        push_msg(3, 8'h33, 0, 0);
        push_msg(0, 8'h34, 0, 0);
        repeat (3) @(posedge clk_i);
        #2;
        chk("rst_header_v", 64'(header_v_o), 64'd0);
        chk("rst_data_v", 64'(data_v_o), 64'd0);
        chk("rst_hdr_ready", 64'(req_header_ready_o), 64'd0);
        chk("rst_data_ready", 64'(req_data_ready_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_grant_id", 64'(grant_id_o), 64'd0);
        hdr_cyc.delete();
        reset_n_i = 1'b1;
        wait_drain(100, "t3_drain");
        chk("t3_hdr_count", 64'(hdr_cyc.size()), 64'd5);
        for (int unsigned k = 1; k < hdr_cyc.size(); k++) begin
            chk("t3_hdr_gap", 64'(hdr_cyc[k] - hdr_cyc[k-1]), 64'd2);
        end

        // 8-beat burst from req 1 under toggling data_ready; req 3 waits for the whole message
        push_msg(1, 8'h40, 8, 8);
        push_msg(3, 8'h41, 0, 0);
        ok = 1'b0;
        for (int unsigned k = 0; k < 200; k++) begin
            @(posedge clk_i);
            #2;
            data_ready_i = ~data_ready_i;
            if (exp_q.size() == 0 && rq_empty()) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t4_drain", 64'(ok), 64'd1);
        data_ready_i = 1'b1;

        // Header stalled for 5 cycles; beats change during the stall must not matter
        header_ready_i = 1'b0;
        push_msg(0, 8'h50, 2, 2);
        ok = 1'b0;
        for (int unsigned k = 0; k < 20; k++) begin
            @(negedge clk_i);
            if (header_v_o) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t5_hdr_seen", 64'(ok), 64'd1);
        bxor[0] = 4'h5;
        for (int unsigned k = 0; k < 5; k++) begin
            chk("t5_hdr_v_stable", 64'(header_v_o), 64'd1);
            chk("t5_hdr_stable", header_o, mk_hdr(0, 8'h50));
            chk("t5_grant_stable", 64'(grant_id_o), 64'd0);
            @(negedge clk_i);
        end
        @(posedge clk_i);
        #2;
        header_ready_i = 1'b1;
        wait_drain(50, "t5_drain");
        bxor[0] = '0;

        // Single 3-beat message from req 2: one idle bubble, then back-to-back beats
        push_msg(2, 8'h20, 3, 3);
        ok = 1'b0;
        for (int unsigned k = 0; k < 20; k++) begin
            @(negedge clk_i);
            if (req_header_v_i[2]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t2_req_seen", 64'(ok), 64'd1);
        chk("t2_bubble_hdr_v", 64'(header_v_o), 64'd0);
        chk("t2_bubble_busy", 64'(busy_o), 64'd0);
        @(negedge clk_i);
        chk("t2_hdr_v", 64'(header_v_o), 64'd1);
        chk("t2_hdr_grant", 64'(grant_id_o), 64'd2);
        for (int unsigned k = 0; k < 3; k++) begin
            @(negedge clk_i);
            chk("t2_beat_v", 64'(data_v_o), 64'd1);
        end
        @(negedge clk_i);
        chk("t2_idle_busy", 64'(busy_o), 64'd0);
        chk("t2_idle_grant", 64'(grant_id_o), 64'd2);
        wait_drain(20, "t2_drain");

        // Reset after 2 of 5 beats: outputs drop at once, partial message is gone
        push_msg(2, 8'h60, 5, 2);
        ok = 1'b0;
        for (int unsigned k = 0; k < 50; k++) begin
            @(posedge clk_i);
            #2;
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t6_two_beats", 64'(ok), 64'd1);
        reset_n_i = 1'b0;
        #1;
        chk("t6_rst_data_v", 64'(data_v_o), 64'd0);
        chk("t6_rst_header_v", 64'(header_v_o), 64'd0);
        chk("t6_rst_busy", 64'(busy_o), 64'd0);
        chk("t6_rst_grant", 64'(grant_id_o), 64'd0);
        chk("t6_rst_data_ready", 64'(req_data_ready_o), 64'd0);
        for (int unsigned i = 0; i < NR; i++) rq[i].delete();
        exp_q.delete();
        repeat (2) @(posedge clk_i);
        #2;
        reset_n_i = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk_i);
            if (header_v_o || data_v_o || busy_o) seen = 1'b1;
        end
        chk("t6_quiet_after_reset", 64'(seen), 64'd0);
        push_msg(1, 8'h61, 1, 1);
        wait_drain(30, "t6_fresh_drain");
        repeat (3) @(negedge clk_i);
        chk("final_exp_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
